// File: rtl/banco_registradores_pkg.sv
// Shared definitions for the multicycle MIPS datapath: special register
// numbers, the RegDST selection encoding and the stack-pointer reset value.
package banco_registradores_pkg;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [4:0]  REG_SP   = 5'd29;
  localparam logic [4:0]  REG_RA   = 5'd31;

  localparam logic [31:0] SP_RESET_DEFAULT = 32'd227;

  // Write-address source selected by the control FSM.
  typedef enum logic [1:0] {
    RS = 2'b00,
    RA = 2'b01,
    SP = 2'b10,
    RT = 2'b11
  } regdst_t;

endpackage

// File: rtl/banco_registradores_registrador.sv
// WIDTH-bit load-enable register with asynchronous active-low clear; used
// for the A/B operand latches.
module registrador #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/banco_registradores.sv
// Architectural register file: 32 entries, $zero hardwired, $sp preset on
// reset, two combinational read ports and A/B operand latches with bypass.
module banco_registradores
  import banco_registradores_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] SP_RESET = WIDTH'(SP_RESET_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [4:0]       WriteReg,
  input  logic [WIDTH-1:0] WriteData,
  input  logic [4:0]       ReadReg1,
  input  logic [4:0]       ReadReg2,
  input  logic             LoadAB,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2
);

  logic [WIDTH-1:0] regs [32];
  logic             write_en;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;

  // Writes to $zero are dropped here so entry 0 stays at its reset value.
  assign write_en = RegWrite && (WriteReg != REG_ZERO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      regs[REG_SP] <= SP_RESET;
    end else if (write_en) begin
      regs[WriteReg] <= WriteData;
    end
  end

  assign ReadData1 = (ReadReg1 == REG_ZERO) ? '0 : regs[ReadReg1];
  assign ReadData2 = (ReadReg2 == REG_ZERO) ? '0 : regs[ReadReg2];

  // A same-edge write to the addressed register is forwarded into the latch.
  always_comb begin
    a_next = ReadData1;
    b_next = ReadData2;
    if (write_en && (WriteReg == ReadReg1)) a_next = WriteData;
    if (write_en && (WriteReg == ReadReg2)) b_next = WriteData;
  end

  registrador #(.WIDTH(WIDTH)) u_reg_a (
    .clk   (clk),
    .reset (reset),
    .load  (LoadAB),
    .d     (a_next),
    .q     (A)
  );

  registrador #(.WIDTH(WIDTH)) u_reg_b (
    .clk   (clk),
    .reset (reset),
    .load  (LoadAB),
    .d     (b_next),
    .q     (B)
  );

endmodule
